// File: rtl/ltp_pkg.sv
// Shared types and default parameters for the multi-channel level-to-pulse converter.
// The optional debounce filter is enabled by defining LTP_DEBOUNCE_EN.
package ltp_pkg;

    typedef enum logic [1:0] {
        LTP_OFF  = 2'b00,
        LTP_RISE = 2'b01,
        LTP_FALL = 2'b10,
        LTP_BOTH = 2'b11
    } edge_mode_e;

    localparam int LTP_N_CH_DEF        = 4;
    localparam int LTP_SYNC_STAGES_DEF = 2;
    localparam int LTP_PULSE_LEN_DEF   = 1;
    localparam int LTP_DB_CYCLES_DEF   = 4;

    function automatic logic mode_qualifies(edge_mode_e mode, logic rise, logic fall);
        logic q;
        unique case (mode)
            LTP_RISE: q = rise;
            LTP_FALL: q = fall;
            LTP_BOTH: q = rise | fall;
            default:  q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/ltp_channel.sv
// One channel: synchroniser, optional debounce (LTP_DEBOUNCE_EN), edge detect,
// retriggerable pulse stretcher and sticky event flag.
module ltp_channel
    import ltp_pkg::*;
#(
    parameter int SYNC_STAGES = LTP_SYNC_STAGES_DEF,
    parameter int PULSE_LEN   = LTP_PULSE_LEN_DEF,
    parameter int DB_CYCLES   = LTP_DB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level_i,
    input  edge_mode_e mode_i,
    input  logic       evt_clr_i,
    output logic       pulse_o,
    output logic       evt_flag_o
);

    localparam int CNT_W = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   filt;
    logic                   prev_q;
    logic                   rise;
    logic                   fall;
    logic                   qualify;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   pulse_q;
    logic                   evt_q;
    logic                   evt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], level_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef LTP_DEBOUNCE_EN
    localparam int DBC_W = $clog2(DB_CYCLES);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DB_CYCLES - 1);

    logic [DBC_W-1:0] dbc_q;
    logic             filt_q;

    // filt only follows sync after DB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbc_q  <= '0;
            filt_q <= 1'b0;
        end else if (sync == filt_q) begin
            dbc_q <= '0;
        end else if (dbc_q == DBC_LAST) begin
            filt_q <= sync;
            dbc_q  <= '0;
        end else begin
            dbc_q <= dbc_q + 1'b1;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync;
`endif

    assign rise    = filt & ~prev_q;
    assign fall    = ~filt & prev_q;
    assign qualify = mode_qualifies(mode_i, rise, fall);

    // A new edge reloads the full length, so overlapping pulses merge.
    always_comb begin
        cnt_d = cnt_q;
        if (qualify) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign evt_d = qualify | (evt_q & ~evt_clr_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            prev_q  <= filt;
            cnt_q   <= cnt_d;
            pulse_q <= (cnt_d != '0);
            evt_q   <= evt_d;
        end
    end

    assign pulse_o    = pulse_q;
    assign evt_flag_o = evt_q;

endmodule

// File: rtl/ltp_multi.sv
// Multi-channel level-to-pulse converter: N_CH independent channels plus a pulse OR.
// Define LTP_DEBOUNCE_EN to add a per-channel debounce filter.
module ltp_multi
    import ltp_pkg::*;
#(
    parameter int N_CH        = LTP_N_CH_DEF,
    parameter int SYNC_STAGES = LTP_SYNC_STAGES_DEF,
    parameter int PULSE_LEN   = LTP_PULSE_LEN_DEF,
    parameter int DB_CYCLES   = LTP_DB_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   level_in,
    input  logic [2*N_CH-1:0] edge_mode,
    input  logic [N_CH-1:0]   evt_clr,
    output logic [N_CH-1:0]   pulse_out,
    output logic              pulse_any,
    output logic [N_CH-1:0]   evt_flag
);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            ltp_channel #(
                .SYNC_STAGES (SYNC_STAGES),
                .PULSE_LEN   (PULSE_LEN),
                .DB_CYCLES   (DB_CYCLES)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .level_i    (level_in[gi]),
                .mode_i     (edge_mode_e'(edge_mode[2*gi+1:2*gi])),
                .evt_clr_i  (evt_clr[gi]),
                .pulse_o    (pulse_out[gi]),
                .evt_flag_o (evt_flag[gi])
            );
        end
    endgenerate

    assign pulse_any = |pulse_out;

endmodule

// File: tb/tb_ltp_multi.sv
// Self-checking bench for ltp_multi: per-cycle model comparison plus directed literal checks.
module tb_ltp_multi;
    import ltp_pkg::*;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int PL = 4;
    localparam int DB = 4;
`ifdef LTP_DEBOUNCE_EN
    localparam int LAT  = SS + DB;
    localparam int HOLD = DB;
`else
    localparam int LAT  = SS;
    localparam int HOLD = 2;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   level_in = '0;
    logic [2*N-1:0] edge_mode = '0;
    logic [N-1:0]   evt_clr = '0;
    logic [N-1:0]   pulse_out;
    logic           pulse_any;
    logic [N-1:0]   evt_flag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ltp_multi #(
        .N_CH        (N),
        .SYNC_STAGES (SS),
        .PULSE_LEN   (PL),
        .DB_CYCLES   (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .level_in  (level_in),
        .edge_mode (edge_mode),
        .evt_clr   (evt_clr),
        .pulse_out (pulse_out),
        .pulse_any (pulse_any),
        .evt_flag  (evt_flag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: history of sampled inputs since reset, filt = sample from SS-1 edges ago,
    // pulse high while fewer than PL edges have passed since the last qualifying edge.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_sync, m_filt, m_prevf, m_pulse, m_evt, m_ns, m_nf;
    logic [1:0]   m_md;
    logic         m_q;
    int           m_last[N];
    int           m_run[N];
    int           ecnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist.delete();
            m_sync = '0; m_filt = '0; m_prevf = '0; m_pulse = '0; m_evt = '0;
            ecnt = 0;
            for (int i = 0; i < N; i++) begin
                m_last[i] = -1000;
                m_run[i]  = 0;
            end
        end else begin
            ecnt++;
            for (int i = 0; i < N; i++) begin
                m_md = edge_mode[2*i +: 2];
                m_q  = (m_md[0] && m_filt[i] && !m_prevf[i]) || (m_md[1] && !m_filt[i] && m_prevf[i]);
                if (m_q) begin
                    m_last[i] = ecnt;
                    m_evt[i]  = 1'b1;
                end else if (evt_clr[i]) begin
                    m_evt[i] = 1'b0;
                end
                m_pulse[i] = (ecnt - m_last[i]) < PL;
            end
            m_prevf = m_filt;
            hist.push_back(level_in);
            m_ns = (ecnt >= SS) ? hist[ecnt-SS] : '0;
`ifdef LTP_DEBOUNCE_EN
            m_nf = m_filt;
            for (int i = 0; i < N; i++) begin
                if (m_sync[i] != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_nf[i]  = m_sync[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
`else
            m_nf = m_ns;
`endif
            m_sync = m_ns;
            m_filt = m_nf;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_pulse_out", pulse_out, '0);
            chk("rst_pulse_any", pulse_any, 1'b0);
            chk("rst_evt_flag", evt_flag, '0);
        end else begin
            chk("model_pulse_out", pulse_out, m_pulse);
            chk("model_pulse_any", pulse_any, |m_pulse);
            chk("model_evt_flag", evt_flag, m_evt);
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    logic [N-1:0] seen;
    int cnt_hi, cnt_any, n_rise, w;
    logic last0;

    initial begin
        // Level high across reset release, rise mode everywhere.
        level_in  = 4'hF;
        edge_mode = 8'h55;
        repeat (3) tick();
        chk("reset_pulse", pulse_out, 4'h0);
        chk("reset_flag", evt_flag, 4'h0);
        chk("reset_any", pulse_any, 1'b0);
        rst = 1'b1;
        for (int j = 0; j < LAT + PL + 2; j++) begin
            tick();
            chk($sformatf("por_pulse_e%0d", j), pulse_out, (j >= LAT && j < LAT + PL) ? 4'hF : 4'h0);
        end
        chk("por_flag", evt_flag, 4'hF);

        // Mode coverage: off/rise/fall/both on ch0..3.
        edge_mode = 8'h00;
        level_in  = 4'h0;
        repeat (LAT + PL + 2) tick();
        evt_clr = 4'hF; tick(); evt_clr = 4'h0;
        chk("clr_all", evt_flag, 4'h0);
        edge_mode = 8'b11_10_01_00;
        level_in  = 4'hF;
        seen = '0;
        repeat (LAT + PL + 2) begin tick(); seen |= pulse_out; end
        chk("mode_rise", seen, 4'b1010);
        level_in = 4'h0;
        seen = '0;
        repeat (LAT + PL + 2) begin tick(); seen |= pulse_out; end
        chk("mode_fall", seen, 4'b1100);
        chk("mode_flags", evt_flag, 4'hE);

        // Retrigger: two ch0 edges HOLD cycles apart merge into one pulse.
        edge_mode = 8'hFF;
        evt_clr = 4'hF; tick(); evt_clr = 4'h0;
        cnt_hi = 0; cnt_any = 0; n_rise = 0; last0 = 1'b0;
        level_in[0] = 1'b1;
        for (int j = 0; j < HOLD + LAT + PL + 4; j++) begin
            if (j == HOLD) level_in[0] = 1'b0;
            tick();
            if (pulse_out[0]) cnt_hi++;
            if (pulse_any) cnt_any++;
            if (pulse_out[0] && !last0) n_rise++;
            last0 = pulse_out[0];
        end
        chk("retrig_len", cnt_hi, PL + HOLD);
        chk("retrig_any_len", cnt_any, PL + HOLD);
        chk("retrig_single", n_rise, 1);

        // Flag race: clear on the qualifying cycle loses, later clear wins.
        edge_mode = 8'h55;
        evt_clr = 4'hF; tick(); evt_clr = 4'h0;
        chk("race_pre", evt_flag, 4'h0);
        level_in[1] = 1'b1;
        repeat (LAT) tick();
        evt_clr = 4'b0010; tick(); evt_clr = 4'h0;
        chk("race_set_wins", evt_flag[1], 1'b1);
        repeat (3) tick();
        evt_clr = 4'b0010; tick(); evt_clr = 4'h0;
        chk("race_clear", evt_flag[1], 1'b0);

        // Async reset in the middle of a ch2 fall pulse.
        edge_mode   = 8'h00;
        level_in[2] = 1'b1;
        repeat (LAT + PL + 2) tick();
        edge_mode   = 8'b00_10_00_00;
        level_in[2] = 1'b0;
        w = 0;
        while (!pulse_out[2] && w < 50) begin tick(); w++; end
        chk("ar_rise_seen", pulse_out[2], 1'b1);
        tick(); tick();
        chk("ar_flag_before", evt_flag[2], 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("ar_pulse_drop", pulse_out, 4'h0);
        chk("ar_flag_drop", evt_flag, 4'h0);
        chk("ar_any_drop", pulse_any, 1'b0);
        repeat (2) tick();
        rst  = 1'b1;
        seen = '0;
        repeat (LAT + PL + 4) begin tick(); seen |= pulse_out; end
        chk("ar_no_resume", seen, 4'h0);

`ifdef LTP_DEBOUNCE_EN
        // Short high is filtered; a DB-long high yields one pulse at SS+DB.
        edge_mode = 8'h01;
        level_in[0] = 1'b1;
        repeat (DB - 1) tick();
        level_in[0] = 1'b0;
        seen = '0;
        repeat (LAT + PL + 4) begin tick(); seen |= pulse_out; end
        chk("db_glitch", seen[0], 1'b0);
        level_in[0] = 1'b1;
        w = 0;
        while (!pulse_out[0] && w < 40) begin tick(); w++; end
        chk("db_latency", w, LAT + 1);
        cnt_hi = 0;
        repeat (PL + 4) begin if (pulse_out[0]) cnt_hi++; tick(); end
        chk("db_len", cnt_hi, PL);
`else
        // One-cycle high on ch3 in both mode: rise then fall, pulse stretched by one.
        edge_mode = 8'b11_00_00_00;
        level_in[3] = 1'b1;
        tick();
        level_in[3] = 1'b0;
        cnt_hi = 0;
        repeat (LAT + PL + 4) begin tick(); if (pulse_out[3]) cnt_hi++; end
        chk("glitch_pair_len", cnt_hi, PL + 1);
        chk("glitch_flag", evt_flag[3], 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
